mc_control_fsm: RTL

//  Multicycle MIPS main control FSM; sequences PC/IR/memory/register file/ALU, drives 2-bit alu_op to aluControl.

---
 rtl/mc_ctrl_pkg.sv | 51 +++++
 rtl/mc_opcode_decode.sv | 22 ++
 rtl/mc_control_fsm.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM.
// Covers states, opcodes, ALU operation codes, mux selects and the decoded opcode class.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] S_RESET   = 4'd0;
    localparam logic [STATE_W-1:0] S_FETCH   = 4'd1;
    localparam logic [STATE_W-1:0] S_DECODE  = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMADR  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMRD   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWB   = 4'd5;
    localparam logic [STATE_W-1:0] S_MEMWR   = 4'd6;
    localparam logic [STATE_W-1:0] S_EXEC    = 4'd7;
    localparam logic [STATE_W-1:0] S_RWB     = 4'd8;
    localparam logic [STATE_W-1:0] S_BRANCH  = 4'd9;
    localparam logic [STATE_W-1:0] S_ADDI_EX = 4'd10;
    localparam logic [STATE_W-1:0] S_ADDI_WB = 4'd11;
    localparam logic [STATE_W-1:0] S_JUMP    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic rtype;
        logic lw;
        logic sw;
        logic beq;
        logic addi;
        logic j;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Classifies the IR opcode field into a one-hot instruction class.
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        case (opcode)
            OP_RTYPE: op_class.rtype   = 1'b1;
            OP_LW:    op_class.lw      = 1'b1;
            OP_SW:    op_class.sw      = 1'b1;
            OP_BEQ:   op_class.beq     = 1'b1;
            OP_ADDI:  op_class.addi    = 1'b1;
            OP_J:     op_class.j       = 1'b1;
            default:  op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired
);

    logic [STATE_W-1:0]  state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire;
    op_class_t           op_class;

    // The branch decision (zero gated by pc_write_cond) is made in the datapath.
    logic unused_zero;
    assign unused_zero = zero;

    mc_opcode_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_comb begin
        // NOTE: every combinational output gets a default before the case, so no latch is inferred.
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALUOP_ADD;
        pc_src        = PCSRC_ALU;
        illegal_op    = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is dispatched.
                alu_src_b  = SRCB_IMM_SH2;
                illegal_op = op_class.illegal;
                state_d    = S_FETCH;
                if (op_class.lw || op_class.sw) state_d = S_MEMADR;
                else if (op_class.rtype)        state_d = S_EXEC;
                else if (op_class.beq)          state_d = S_BRANCH;
                else if (op_class.addi)         state_d = S_ADDI_EX;
                else if (op_class.j)            state_d = S_JUMP;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = op_class.sw ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
    end

    assign retired_d = retire ? retired_q + RETIRE_W'(1) : retired_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_RESET;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign retired = retired_q;

endmodule
